// File: rtl/sap_control_unit.sv
// ---------------------------------------------------------------------------
// sap_control_unit
//   Microsequencer for the 8-bit bus CPU. Steps a five-state T counter and
//   decodes the 4-bit opcode into per-cycle control strobes. Strobes are
//   combinational from step/opcode/flags/halted; only step and halted are
//   registered.
//
//   Build option: define CU_COND_JUMP_EN to enable JC (0111) / JZ (1000).
//   Without it those opcodes decode as NOP and cf/zf are ignored.
//
//   Parameter:
//     EARLY_END  1: return to T0 right after an instruction's last active step
//                0: always run T0..T4
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     opcode[3:0]       upper nibble of the instruction register
//     cf, zf            registered ALU carry / zero flags
//     step[2:0]         current T-state (0..4)
//     halted            sticky halt indicator, cleared only by rst
//     co ce j           PC out / increment / load
//     mi ro ri          MAR load, RAM out, RAM write
//     ii io             IR load, IR operand out
//     ai ao bi          A load, A out, B load
//     alu_eo alu_sub    ALU result out, subtract select
//     oi                output register load
// ---------------------------------------------------------------------------
module sap_control_unit #(
    parameter int unsigned EARLY_END = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic [2:0] step,
    output logic       halted,
    output logic       co,
    output logic       ce,
    output logic       j,
    output logic       mi,
    output logic       ro,
    output logic       ri,
    output logic       ii,
    output logic       io,
    output logic       ai,
    output logic       ao,
    output logic       bi,
    output logic       alu_eo,
    output logic       alu_sub,
    output logic       oi
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] step_next;
    logic       halted_next;
    logic [2:0] last_step;
    logic       jump_taken;
    logic       active;

`ifdef CU_COND_JUMP_EN
    // Flags are sampled live; the ALU registers them on the ADD/SUB T4 edge.
    assign jump_taken = ((opcode == OP_JC) && cf) || ((opcode == OP_JZ) && zf);
`else
    logic unused_flags;
    assign jump_taken   = 1'b0;
    assign unused_flags = cf ^ zf;
`endif

    // Strobes are suppressed during reset and after halt.
    assign active = !rst && !halted;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            halted <= halted_next;
        end
    end

    // Last step that does useful work, used for early termination.
    always_comb begin
        last_step = T1;
        case (opcode)
            OP_LDA, OP_STA:         last_step = T3;
            OP_ADD, OP_SUB:         last_step = T4;
            OP_LDI, OP_JMP, OP_OUT: last_step = T2;
            OP_HLT:                 last_step = T2;
`ifdef CU_COND_JUMP_EN
            OP_JC, OP_JZ:           last_step = jump_taken ? T2 : T1;
`endif
            default:                last_step = T1;
        endcase
    end

    // Next-state: HLT freezes at T2 with halted set; otherwise advance/wrap.
    always_comb begin
        step_next   = step;
        halted_next = halted;
        if (!halted) begin
            if ((step == T2) && (opcode == OP_HLT)) begin
                halted_next = 1'b1;
            end else if ((EARLY_END != 0) && (step == last_step)) begin
                step_next = T0;
            end else if (step >= T4) begin
                step_next = T0;
            end else begin
                step_next = step + 3'd1;
            end
        end
    end

    // Control strobe decode
    always_comb begin
        co      = 1'b0;
        ce      = 1'b0;
        j       = 1'b0;
        mi      = 1'b0;
        ro      = 1'b0;
        ri      = 1'b0;
        ii      = 1'b0;
        io      = 1'b0;
        ai      = 1'b0;
        ao      = 1'b0;
        bi      = 1'b0;
        alu_eo  = 1'b0;
        alu_sub = 1'b0;
        oi      = 1'b0;
        if (active) begin
            case (step)
                T0: begin
                    co = 1'b1;
                    mi = 1'b1;
                end
                T1: begin
                    ro = 1'b1;
                    ii = 1'b1;
                    ce = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            io = 1'b1;
                            mi = 1'b1;
                        end
                        OP_LDI: begin
                            io = 1'b1;
                            ai = 1'b1;
                        end
                        OP_JMP: begin
                            io = 1'b1;
                            j  = 1'b1;
                        end
`ifdef CU_COND_JUMP_EN
                        OP_JC, OP_JZ: begin
                            io = jump_taken;
                            j  = jump_taken;
                        end
`endif
                        OP_OUT: begin
                            ao = 1'b1;
                            oi = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ro = 1'b1;
                            ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ro = 1'b1;
                            bi = 1'b1;
                        end
                        OP_STA: begin
                            ao = 1'b1;
                            ri = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        alu_eo  = 1'b1;
                        ai      = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_unit.sv
module tb_sap_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       cf;
    logic       zf;

    logic [2:0] step, step_f;
    logic       halted, halted_f;
    logic co, ce, j, mi, ro, ri, ii, io, ai, ao, bi, alu_eo, alu_sub, oi;
    logic co_f, ce_f, j_f, mi_f, ro_f, ri_f, ii_f, io_f, ai_f, ao_f, bi_f,
          alu_eo_f, alu_sub_f, oi_f;

    logic [13:0] ctl, ctl_f;
    assign ctl   = {co, ce, j, mi, ro, ri, ii, io, ai, ao, bi, alu_eo, alu_sub, oi};
    assign ctl_f = {co_f, ce_f, j_f, mi_f, ro_f, ri_f, ii_f, io_f, ai_f, ao_f,
                    bi_f, alu_eo_f, alu_sub_f, oi_f};

    localparam logic [13:0] M_CO  = 14'h2000;
    localparam logic [13:0] M_CE  = 14'h1000;
    localparam logic [13:0] M_J   = 14'h0800;
    localparam logic [13:0] M_MI  = 14'h0400;
    localparam logic [13:0] M_RO  = 14'h0200;
    localparam logic [13:0] M_II  = 14'h0080;
    localparam logic [13:0] M_IO  = 14'h0040;
    localparam logic [13:0] M_AI  = 14'h0020;
    localparam logic [13:0] M_BI  = 14'h0008;
    localparam logic [13:0] M_EO  = 14'h0004;
    localparam logic [13:0] M_SUB = 14'h0002;

    int passed = 0;
    int total  = 0;

    sap_control_unit #(.EARLY_END(1)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
        .step(step), .halted(halted),
        .co(co), .ce(ce), .j(j), .mi(mi), .ro(ro), .ri(ri), .ii(ii), .io(io),
        .ai(ai), .ao(ao), .bi(bi), .alu_eo(alu_eo), .alu_sub(alu_sub), .oi(oi)
    );

    sap_control_unit #(.EARLY_END(0)) u_full (
        .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
        .step(step_f), .halted(halted_f),
        .co(co_f), .ce(ce_f), .j(j_f), .mi(mi_f), .ro(ro_f), .ri(ri_f),
        .ii(ii_f), .io(io_f), .ai(ai_f), .ao(ao_f), .bi(bi_f),
        .alu_eo(alu_eo_f), .alu_sub(alu_sub_f), .oi(oi_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset both instances and release on a falling edge; T0 begins there.
    task automatic start(input logic [3:0] op, input logic c, input logic z);
        rst    = 1'b1;
        opcode = op;
        cf     = c;
        zf     = z;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 4'h2; cf = 1'b0; zf = 1'b0;
        #1;
        total++; if (step !== 3'd0) $display("FAIL reset_step: got %0d expected 0", step); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else passed++;
        total++; if (ctl !== 14'h0) $display("FAIL reset_ctl: got %h expected 0000", ctl); else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (step !== 3'd3 || ctl !== (M_RO | M_BI))
            $display("FAIL reset_pre_t3: got step %0d ctl %h expected step 3 ctl %h", step, ctl, M_RO | M_BI);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (step !== 3'd0 || ctl !== 14'h0)
            $display("FAIL reset_mid_add: got step %0d ctl %h expected step 0 ctl 0000", step, ctl);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (step !== 3'd0 || ctl !== (M_CO | M_MI))
            $display("FAIL reset_resume_t0: got step %0d ctl %h expected step 0 ctl %h", step, ctl, M_CO | M_MI);
        else passed++;
        @(negedge clk);
        #1;
        total++; if (step !== 3'd1) $display("FAIL reset_resume_t1: got %0d expected 1", step); else passed++;
    endtask

    task automatic test_add();
        logic [13:0] exp [5];
        exp = '{M_CO | M_MI, M_RO | M_II | M_CE, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI};
        start(4'h2, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (step !== 3'(k) || ctl !== exp[k])
                $display("FAIL add_t%0d: got step %0d ctl %h expected step %0d ctl %h", k, step, ctl, k, exp[k]);
            else passed++;
            @(negedge clk);
        end
        #1;
        total++; if (step !== 3'd0) $display("FAIL add_wrap: got %0d expected 0", step); else passed++;
    endtask

    task automatic test_sub_ldi();
        start(4'h3, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        total++; if (step !== 3'd4 || ctl !== (M_EO | M_SUB | M_AI))
            $display("FAIL sub_t4: got step %0d ctl %h expected step 4 ctl %h", step, ctl, M_EO | M_SUB | M_AI);
        else passed++;
        @(negedge clk);
        #1;
        total++; if (step !== 3'd0) $display("FAIL sub_wrap: got %0d expected 0", step); else passed++;

        start(4'h5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        total++; if (step !== 3'd2 || ctl !== (M_IO | M_AI))
            $display("FAIL ldi_t2: got step %0d ctl %h expected step 2 ctl %h", step, ctl, M_IO | M_AI);
        else passed++;
        @(negedge clk);
        #1;
        total++; if (step !== 3'd0 || ctl !== (M_CO | M_MI))
            $display("FAIL ldi_wrap: got step %0d ctl %h expected step 0 ctl %h", step, ctl, M_CO | M_MI);
        else passed++;
    endtask

    task automatic test_cond_jump();
`ifdef CU_COND_JUMP_EN
        start(4'h7, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        total++; if (step !== 3'd2 || ctl !== (M_IO | M_J))
            $display("FAIL jc_taken_t2: got step %0d ctl %h expected step 2 ctl %h", step, ctl, M_IO | M_J);
        else passed++;
        @(negedge clk);
        #1;
        total++; if (step !== 3'd0) $display("FAIL jc_taken_wrap: got %0d expected 0", step); else passed++;

        start(4'h7, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        total++; if (step !== 3'd1 || ctl !== (M_RO | M_II | M_CE))
            $display("FAIL jc_untaken_t1: got step %0d ctl %h expected step 1 ctl %h", step, ctl, M_RO | M_II | M_CE);
        else passed++;
        @(negedge clk);
        #1;
        total++; if (step !== 3'd0) $display("FAIL jc_untaken_wrap: got %0d expected 0", step); else passed++;

        start(4'h8, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        total++; if (step !== 3'd2 || ctl !== (M_IO | M_J))
            $display("FAIL jz_taken_t2: got step %0d ctl %h expected step 2 ctl %h", step, ctl, M_IO | M_J);
        else passed++;

        start(4'h8, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        total++; if (step !== 3'd0) $display("FAIL jz_untaken_wrap: got %0d expected 0", step); else passed++;
`else
        for (int op = 7; op <= 8; op++) begin
            start(4'(op), 1'b1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                #1;
                total++;
                if (j !== 1'b0 || j_f !== 1'b0)
                    $display("FAIL nojump_op%0d_c%0d: got j %b j_full %b expected 0 0", op, k, j, j_f);
                else passed++;
                @(negedge clk);
            end
            #1;
            total++; if (step !== 3'd1) $display("FAIL nojump_op%0d_step: got %0d expected 1", op, step); else passed++;
        end
`endif
    endtask

    task automatic test_halt();
        start(4'hF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        total++; if (step !== 3'd2 || ctl !== 14'h0 || halted !== 1'b0)
            $display("FAIL hlt_t2: got step %0d ctl %h halted %b expected step 2 ctl 0000 halted 0", step, ctl, halted);
        else passed++;
        @(negedge clk);
        #1;
        total++; if (halted !== 1'b1) $display("FAIL hlt_set: got %b expected 1", halted); else passed++;
        for (int k = 0; k < 10; k++) begin
            total++;
            if (step !== 3'd2 || ctl !== 14'h0)
                $display("FAIL hlt_hold_%0d: got step %0d ctl %h expected step 2 ctl 0000", k, step, ctl);
            else passed++;
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        total++; if (halted !== 1'b0 || step !== 3'd0)
            $display("FAIL hlt_clear: got halted %b step %0d expected 0 0", halted, step);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_length();
        for (int op = 0; op < 16; op++) begin
            start(4'(op), 1'b1, 1'b1);
            for (int k = 0; k < 5; k++) begin
                logic [2:0] exp_step;
                exp_step = (op == 15 && k > 2) ? 3'd2 : 3'(k);
                #1;
                total++;
                if (step_f !== exp_step)
                    $display("FAIL full_op%0d_step%0d: got %0d expected %0d", op, k, step_f, exp_step);
                else passed++;
                total++;
                if ($countones({co_f, ro_f, io_f, ao_f, alu_eo_f}) > 1 || (alu_sub_f && !alu_eo_f))
                    $display("FAIL full_op%0d_bus%0d: got ctl %h expected one driver", op, k, ctl_f);
                else passed++;
                if (op == 0 && k >= 2) begin
                    total++;
                    if (ctl_f !== 14'h0)
                        $display("FAIL full_nop_t%0d: got ctl %h expected 0000", k, ctl_f);
                    else passed++;
                end
                @(negedge clk);
            end
            if (op != 15) begin
                #1;
                total++;
                if (step_f !== 3'd0)
                    $display("FAIL full_op%0d_wrap: got %0d expected 0", op, step_f);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_ldi();
        test_cond_jump();
        test_halt();
        test_full_length();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
